// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: one write port, packed read ports and the
// bulk-clear busy/done handshake.
interface regfile_multiport_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
);
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     clr_req;
    logic                     busy;
    logic                     clr_done;

    modport master (
        output we, waddr, wdata, rd_addr, clr_req,
        input  rd_data, busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, rd_addr, clr_req,
        output rd_data, busy, clr_done
    );
endinterface

// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with write-first bypass, optional
// hardwired-zero entry, optional registered reads and a sequenced bulk clear.
module regfile_multiport #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int REG_RD   = 0
) (
    input  logic               clk,
    input  logic               reset,
    regfile_multiport_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        ptr;
    logic                     busy_q;
    logic                     done_q;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     wr_en;
    logic [NUM_RD*DATA_W-1:0] rd_val;

    // A write aimed at the hardwired zero entry is dropped entirely, so it can never bypass either.
    assign wr_en = bus.we && !busy_q && !((ZERO_REG != 0) && (bus.waddr == '0));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.clr_req) begin
                        state  <= ST_CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // The last entry ends the sweep; ptr parks there rather than wrapping.
                    if (ptr == '1) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array is flop-based and cleared by reset, so it will not map onto a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy_q) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // NOTE: rd_val takes a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if ((ZERO_REG != 0) && (bus.rd_addr[i*ADDR_W +: ADDR_W] == '0)) begin
                rd_val[i*DATA_W +: DATA_W] = '0;
            end else if (wr_en && (bus.waddr == bus.rd_addr[i*ADDR_W +: ADDR_W])) begin
                rd_val[i*DATA_W +: DATA_W] = bus.wdata;
            end else begin
                rd_val[i*DATA_W +: DATA_W] = mem[bus.rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            logic [NUM_RD*DATA_W-1:0] rd_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_val;
                end
            end

            assign bus.rd_data = rd_q;
        end else begin : g_comb_rd
            assign bus.rd_data = rd_val;
        end
    endgenerate

    assign bus.busy     = busy_q;
    assign bus.clr_done = done_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: three 8x8 variants share one stimulus
// stream, and a 16-bit/32-entry/4-port variant covers the scaled configuration.
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [5:0] rd_addr;
    logic       clr_req;

    logic        b_we;
    logic [4:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [19:0] b_rd_addr;
    logic        b_clr_req;

    regfile_multiport_if #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) bus_c ();
    regfile_multiport_if #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) bus_z ();
    regfile_multiport_if #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) bus_r ();
    regfile_multiport_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4)) bus_b ();

    assign bus_c.we = we;  assign bus_c.waddr = waddr;  assign bus_c.wdata = wdata;
    assign bus_c.rd_addr = rd_addr;  assign bus_c.clr_req = clr_req;
    assign bus_z.we = we;  assign bus_z.waddr = waddr;  assign bus_z.wdata = wdata;
    assign bus_z.rd_addr = rd_addr;  assign bus_z.clr_req = clr_req;
    assign bus_r.we = we;  assign bus_r.waddr = waddr;  assign bus_r.wdata = wdata;
    assign bus_r.rd_addr = rd_addr;  assign bus_r.clr_req = clr_req;
    assign bus_b.we = b_we;  assign bus_b.waddr = b_waddr;  assign bus_b.wdata = b_wdata;
    assign bus_b.rd_addr = b_rd_addr;  assign bus_b.clr_req = b_clr_req;

    regfile_multiport #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .REG_RD(0))
        u_c (.clk(clk), .reset(reset), .bus(bus_c));
    regfile_multiport #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .REG_RD(0))
        u_z (.clk(clk), .reset(reset), .bus(bus_z));
    regfile_multiport #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .REG_RD(1))
        u_r (.clk(clk), .reset(reset), .bus(bus_r));
    regfile_multiport #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0), .REG_RD(0))
        u_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One stimulus cycle: inputs plus the expected same-cycle read data of the
    // plain variant (c*) and the zero-entry variant (z*).
    typedef struct packed {
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] z0;
        logic [7:0] z1;
    } vec_t;

    vec_t        vecs [10];
    logic [15:0] r_prev;
    int          busy_cnt;
    int          done_seen;
    int          stray;

    initial begin
        vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 8'hA5, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 3'd7, 8'h3C, 3'd3, 3'd7, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[3] = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 3'd5, 8'h77, 3'd5, 3'd3, 8'h77, 8'hA5, 8'h77, 8'hA5};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h77, 8'h77, 8'h77, 8'h77};
        vecs[6] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd1, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[7] = '{1'b1, 3'd1, 8'hFF, 3'd0, 3'd1, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        vecs[8] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        vecs[9] = '{1'b1, 3'd2, 8'h5A, 3'd2, 3'd2, 8'h5A, 8'h5A, 8'h5A, 8'h5A};

        reset = 1'b1;
        we = 1'b0;  waddr = '0;  wdata = '0;  rd_addr = '0;  clr_req = 1'b0;
        b_we = 1'b0;  b_waddr = '0;  b_wdata = '0;  b_rd_addr = '0;  b_clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        #1;
        check("reset_c_rd", bus_c.rd_data, 16'h0000);
        check("reset_r_rd", bus_r.rd_data, 16'h0000);
        check("reset_busy", bus_c.busy, 1'b0);
        check("reset_done", bus_c.clr_done, 1'b0);
        @(posedge clk); #1;

        // Table: same-cycle reads on u_c/u_z; u_r must show the previous row's value
        // before the edge and this row's bypassed value after it.
        r_prev = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            we = vecs[k].we;  waddr = vecs[k].waddr;  wdata = vecs[k].wdata;
            rd_addr = {vecs[k].ra1, vecs[k].ra0};
            #1;
            check($sformatf("vec%0d_comb", k), bus_c.rd_data, {vecs[k].c1, vecs[k].c0});
            check($sformatf("vec%0d_zero", k), bus_z.rd_data, {vecs[k].z1, vecs[k].z0});
            check($sformatf("vec%0d_reg_hold", k), bus_r.rd_data, r_prev);
            @(posedge clk); #1;
            check($sformatf("vec%0d_reg_new", k), bus_r.rd_data, {vecs[k].c1, vecs[k].c0});
            r_prev = {vecs[k].c1, vecs[k].c0};
        end
        we = 1'b0;

        // Bulk clear: fill every entry, then sweep with clr_req held through DONE.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1;  waddr = 3'(i);  wdata = 8'h10 + 8'(i);
            @(posedge clk); #1;
        end
        we = 1'b0;
        clr_req = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            we = (k == 5);  waddr = 3'd2;  wdata = 8'h11;  rd_addr = {3'd6, 3'd2};
            #1;
            check($sformatf("clr_busy_c%0d", k), bus_c.busy, 1'b1);
            check($sformatf("clr_nodone_c%0d", k), bus_c.clr_done, 1'b0);
            if (k == 5) check("clr_partial_sweep", bus_c.rd_data, {8'h16, 8'h00});
            @(posedge clk); #1;
        end
        we = 1'b1;  waddr = 3'd4;  wdata = 8'h44;  rd_addr = {3'd2, 3'd4};
        #1;
        check("done_busy", bus_c.busy, 1'b0);
        check("done_pulse", bus_c.clr_done, 1'b1);
        check("done_write_bypass", bus_c.rd_data, {8'h00, 8'h44});
        @(posedge clk); #1;
        we = 1'b0;  clr_req = 1'b0;
        #1;
        check("idle_busy", bus_c.busy, 1'b0);
        check("idle_done_low", bus_c.clr_done, 1'b0);
        @(posedge clk); #1;
        check("no_restart_from_done", bus_c.busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = {3'(i), 3'(i)};
            #1;
            check($sformatf("cleared_addr%0d", i), bus_c.rd_data,
                  (i == 4) ? 16'h4444 : 16'h0000);
        end
        @(posedge clk); #1;

        // Reset in the 4th CLEAR cycle aborts the sweep with no done pulse.
        we = 1'b1;  waddr = 3'd3;  wdata = 8'h33;
        @(posedge clk); #1;
        waddr = 3'd6;  wdata = 8'h66;
        @(posedge clk); #1;
        we = 1'b0;  clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", bus_c.busy, 1'b1);
        reset = 1'b1;
        rd_addr = {3'd6, 3'd3};
        #1;
        check("abort_busy", bus_c.busy, 1'b0);
        check("abort_done", bus_c.clr_done, 1'b0);
        check("abort_array_zero", bus_c.rd_data, 16'h0000);
        check("abort_reg_rd_zero", bus_r.rd_data, 16'h0000);
        reset = 1'b0;
        stray = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus_c.clr_done || bus_c.busy) stray++;
        end
        check("abort_no_done_later", stray, 0);
        we = 1'b1;  waddr = 3'd5;  wdata = 8'h55;  rd_addr = {3'd6, 3'd5};
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check("post_abort_rw", bus_c.rd_data, {8'h00, 8'h55});
        check("post_abort_reg_rw", bus_r.rd_data, {8'h00, 8'h55});

        // Scaled configuration: 16-bit data, 32 entries, four read ports.
        b_we = 1'b1;  b_waddr = 5'd0;  b_wdata = 16'h1234;
        @(posedge clk); #1;
        b_waddr = 5'd15;  b_wdata = 16'hBEEF;
        @(posedge clk); #1;
        b_waddr = 5'd31;  b_wdata = 16'hCAFE;
        @(posedge clk); #1;
        b_we = 1'b0;
        b_rd_addr = {5'd15, 5'd31, 5'd15, 5'd0};
        #1;
        check("big_read_a", bus_b.rd_data, {16'hBEEF, 16'hCAFE, 16'hBEEF, 16'h1234});
        b_rd_addr = {5'd0, 5'd1, 5'd31, 5'd15};
        #1;
        check("big_read_b", bus_b.rd_data, {16'h1234, 16'h0000, 16'hCAFE, 16'hBEEF});
        @(posedge clk); #1;
        b_clr_req = 1'b1;
        @(posedge clk); #1;
        b_clr_req = 1'b0;
        busy_cnt  = 0;
        done_seen = 0;
        for (int k = 0; k < 100 && done_seen == 0; k++) begin
            if (bus_b.busy) busy_cnt++;
            if (bus_b.clr_done) done_seen = 1;
            @(posedge clk); #1;
        end
        check("big_clear_busy_cycles", busy_cnt, 32);
        check("big_clear_done_seen", done_seen, 1);
        b_rd_addr = {5'd31, 5'd15, 5'd0, 5'd1};
        #1;
        check("big_cleared", bus_b.rd_data, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
